// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: port identifiers, the read tag
// carried alongside each RAM read, and the default RAM read latency.
package dmem_arb_pkg;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_HOST = 1'b1
  } port_t;

  typedef struct packed {
    logic  valid;
    port_t port;
    logic  err;
  } rd_tag_t;

  localparam int DMEM_RD_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Read tag pipeline: RD_LATENCY-deep shift register of rd_tag_t that travels
// in lockstep with the RAM read path, so the tail entry lines up with douta.
// Cleared asynchronously together with the RAM output registers.
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LATENCY = DMEM_RD_LATENCY_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_head,
  output rd_tag_t tag_tail,
  output logic    busy
);

  rd_tag_t stage [RD_LATENCY];

  // Shift the tag chain one stage per clock; reset drops every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_head;
      for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  // Busy whenever any stage holds a read that still owes a response.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) busy = busy | stage[i].valid;
  end

  assign tag_tail = stage[RD_LATENCY-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter in front of the single-port data BRAM.
// Build option: define DMEM_ARB_RR_EN for round-robin on contention;
// left undefined, the core always wins contention (host may starve).
// The RAM's rsta must be tied to rst_in so douta and the tag pipe clear together.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = DMEM_RD_LATENCY_DEFAULT
) (
  input  logic              clk_100mhz,
  input  logic              rst_in,
  input  logic              core_req_in,
  input  logic              core_we_in,
  input  logic [31:0]       core_addr_in,
  input  logic [DATA_W-1:0] core_wdata_in,
  output logic              core_gnt_out,
  output logic              core_rvalid_out,
  output logic [DATA_W-1:0] core_rdata_out,
  output logic              core_err_out,
  input  logic              host_req_in,
  input  logic              host_we_in,
  input  logic [31:0]       host_addr_in,
  input  logic [DATA_W-1:0] host_wdata_in,
  output logic              host_gnt_out,
  output logic              host_rvalid_out,
  output logic [DATA_W-1:0] host_rdata_out,
  output logic              host_err_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [DATA_W-1:0] ram_din_out,
  output logic              ram_we_out,
  input  logic [DATA_W-1:0] ram_dout_in,
  output logic              busy_out
);

  port_t             last_gnt;
  logic              grant_core;
  logic              grant_host;
  logic              granted;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;
  logic [ADDR_W-1:0] addr_hold;
  rd_tag_t           tag_head;
  rd_tag_t           tag_tail;
  logic              unused_addr_bits;

  // Grant decision; gated by reset so no grant is visible while held in reset.
  always_comb begin
    grant_core = 1'b0;
    grant_host = 1'b0;
    if (!rst_in) begin
      if (core_req_in && host_req_in) begin
`ifdef DMEM_ARB_RR_EN
        if (last_gnt == PORT_HOST) grant_core = 1'b1;
        else                       grant_host = 1'b1;
`else
        grant_core = 1'b1;
`endif
      end else begin
        grant_core = core_req_in;
        grant_host = host_req_in;
      end
    end
  end

  assign granted   = grant_core | grant_host;
  assign sel_we    = grant_host ? host_we_in    : core_we_in;
  assign sel_addr  = grant_host ? host_addr_in  : core_addr_in;
  assign sel_wdata = grant_host ? host_wdata_in : core_wdata_in;
  assign misaligned = (sel_addr[1:0] != 2'b00);
  assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

  assign core_gnt_out = grant_core;
  assign host_gnt_out = grant_host;
  // Misaligned stores are accepted but never reach the array.
  assign ram_we_out   = granted & sel_we & ~misaligned;
  assign ram_addr_out = granted ? sel_addr[ADDR_W+1:2] : addr_hold;
  assign ram_din_out  = granted ? sel_wdata : '0;

  // Remember the last granted port and RAM address across idle cycles.
  always_ff @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      last_gnt  <= PORT_HOST;
      addr_hold <= '0;
    end else if (granted) begin
      last_gnt  <= grant_host ? PORT_HOST : PORT_CORE;
      addr_hold <= sel_addr[ADDR_W+1:2];
    end
  end

  // Only loads and misaligned accesses owe a response; aligned stores are silent.
  always_comb begin
    tag_head       = '0;
    tag_head.valid = granted & (~sel_we | misaligned);
    tag_head.port  = grant_host ? PORT_HOST : PORT_CORE;
    tag_head.err   = misaligned;
  end

  dmem_rd_tag_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tag_pipe (
    .clk      (clk_100mhz),
    .rst      (rst_in),
    .tag_head (tag_head),
    .tag_tail (tag_tail),
    .busy     (busy_out)
  );

  assign core_rvalid_out = tag_tail.valid & (tag_tail.port == PORT_CORE);
  assign host_rvalid_out = tag_tail.valid & (tag_tail.port == PORT_HOST);
  assign core_err_out    = core_rvalid_out & tag_tail.err;
  assign host_err_out    = host_rvalid_out & tag_tail.err;
  assign core_rdata_out  = (core_rvalid_out && !tag_tail.err) ? ram_dout_in : '0;
  assign host_rdata_out  = (host_rvalid_out && !tag_tail.err) ? ram_dout_in : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model (word array, last-winner record,
// queue of owed responses with due cycles). Follows DMEM_ARB_RR_EN if defined.
module tb_dmem_arbiter;

  logic        clk_100mhz = 1'b0;
  logic        rst_in = 1'b1;
  logic        core_req_in = 0, core_we_in = 0;
  logic [31:0] core_addr_in = 0, core_wdata_in = 0;
  logic        host_req_in = 0, host_we_in = 0;
  logic [31:0] host_addr_in = 0, host_wdata_in = 0;
  logic        core_gnt_out, core_rvalid_out, core_err_out;
  logic        host_gnt_out, host_rvalid_out, host_err_out;
  logic [31:0] core_rdata_out, host_rdata_out;
  logic [11:0] ram_addr_out;
  logic [31:0] ram_din_out, ram_dout_in;
  logic        ram_we_out, busy_out;

  always #5 clk_100mhz = ~clk_100mhz;

  dmem_arbiter dut (
    .clk_100mhz      (clk_100mhz),
    .rst_in          (rst_in),
    .core_req_in     (core_req_in),
    .core_we_in      (core_we_in),
    .core_addr_in    (core_addr_in),
    .core_wdata_in   (core_wdata_in),
    .core_gnt_out    (core_gnt_out),
    .core_rvalid_out (core_rvalid_out),
    .core_rdata_out  (core_rdata_out),
    .core_err_out    (core_err_out),
    .host_req_in     (host_req_in),
    .host_we_in      (host_we_in),
    .host_addr_in    (host_addr_in),
    .host_wdata_in   (host_wdata_in),
    .host_gnt_out    (host_gnt_out),
    .host_rvalid_out (host_rvalid_out),
    .host_rdata_out  (host_rdata_out),
    .host_err_out    (host_err_out),
    .ram_addr_out    (ram_addr_out),
    .ram_din_out     (ram_din_out),
    .ram_we_out      (ram_we_out),
    .ram_dout_in     (ram_dout_in),
    .busy_out        (busy_out)
  );

  // Read-first BRAM with two output register stages; rsta tied to rst_in.
  logic [31:0] ram_mem [4096];
  logic [31:0] ram_r1, ram_r2;
  always @(posedge clk_100mhz or posedge rst_in) begin
    if (rst_in) begin
      ram_r1 <= '0;
      ram_r2 <= '0;
    end else begin
      if (ram_we_out) ram_mem[ram_addr_out] <= ram_din_out;
      ram_r1 <= ram_mem[ram_addr_out];
      ram_r2 <= ram_r1;
    end
  end
  assign ram_dout_in = ram_r2;

  typedef struct {
    int          due;
    logic        port;   // 0 core, 1 host
    logic        err;
    logic [31:0] data;
  } resp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [64];
  logic        m_last = 1'b1;   // 1 = host won last
  logic [11:0] m_hold = '0;
  resp_t       pend [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
    logic        gc, gh, we, mis, rv_c, rv_h, er, busy_e;
    logic [31:0] a, d, rd;
    int          hit;
    @(posedge clk_100mhz);
    #1;
    cyc++;
    core_req_in = cr; core_we_in = cw; core_addr_in = ca; core_wdata_in = cd;
    host_req_in = hr; host_we_in = hw; host_addr_in = ha; host_wdata_in = hd;
    #1;
    if (cr && hr) begin
`ifdef DMEM_ARB_RR_EN
      gc = m_last;
`else
      gc = 1'b1;
`endif
      gh = !gc;
    end else begin
      gc = cr;
      gh = hr;
    end
    we  = gh ? hw : cw;
    a   = gh ? ha : ca;
    d   = gh ? hd : cd;
    mis = (a[1:0] != 2'b00);
    chk("core_gnt", {31'b0, core_gnt_out}, {31'b0, gc});
    chk("host_gnt", {31'b0, host_gnt_out}, {31'b0, gh});
    chk("ram_we", {31'b0, ram_we_out}, {31'b0, (gc | gh) & we & !mis});
    chk("ram_addr", {20'b0, ram_addr_out}, {20'b0, (gc | gh) ? a[13:2] : m_hold});
    chk("ram_din", ram_din_out, (gc | gh) ? d : 32'h0);

    hit = -1;
    foreach (pend[i]) if (pend[i].due == cyc) hit = i;
    rv_c = 0; rv_h = 0; er = 0; rd = 0;
    if (hit >= 0) begin
      rv_c = !pend[hit].port;
      rv_h = pend[hit].port;
      er   = pend[hit].err;
      rd   = pend[hit].data;
    end
    busy_e = (pend.size() != 0);
    chk("core_rvalid", {31'b0, core_rvalid_out}, {31'b0, rv_c});
    chk("host_rvalid", {31'b0, host_rvalid_out}, {31'b0, rv_h});
    chk("core_err", {31'b0, core_err_out}, {31'b0, rv_c & er});
    chk("host_err", {31'b0, host_err_out}, {31'b0, rv_h & er});
    chk("core_rdata", core_rdata_out, rv_c ? rd : 32'h0);
    chk("host_rdata", host_rdata_out, rv_h ? rd : 32'h0);
    chk("busy", {31'b0, busy_out}, {31'b0, busy_e});

    if (hit >= 0) pend.delete(hit);
    if (gc | gh) begin
      m_last = gh;
      m_hold = a[13:2];
      if (!we || mis) pend.push_back('{due: cyc + 2, port: gh, err: mis,
                                       data: mis ? 32'h0 : ref_mem[a[7:2]]});
      if (we && !mis) ref_mem[a[7:2]] = d;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset values with requests asserted: grants must stay low.
    core_req_in = 1; host_req_in = 1;
    #3;
    chk("rst_core_gnt", {31'b0, core_gnt_out}, 32'h0);
    chk("rst_host_gnt", {31'b0, host_gnt_out}, 32'h0);
    chk("rst_ram_addr", {20'b0, ram_addr_out}, 32'h0);
    chk("rst_ram_din", ram_din_out, 32'h0);
    chk("rst_ram_we", {31'b0, ram_we_out}, 32'h0);
    chk("rst_busy", {31'b0, busy_out}, 32'h0);
    core_req_in = 0; host_req_in = 0;
    #20 rst_in = 0;

    // Host preloads the first 64 words.
    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, 1, 1, i * 4, $urandom);

    // Core store then load of the same word.
    step(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 32'h40, 0, 0, 0, 0, 0);
    idle(3);

    // Continuous dual loads, then core drops its request.
    for (int i = 0; i < 6; i++) step(1, 0, i * 4, 0, 1, 0, 32'h80 + i * 4, 0);
    step(0, 0, 0, 0, 1, 0, 32'h90, 0);
    idle(3);

    // Misaligned host store: accepted, no write, error response.
    step(0, 0, 0, 0, 1, 1, 32'h41, 32'h12345678);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 32'h40, 0);
    idle(3);

    // Back-to-back core loads.
    step(1, 0, 32'h0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h4, 0, 0, 0, 0, 0);
    step(1, 0, 32'h8, 0, 0, 0, 0, 0);
    idle(4);

    // Reset in the middle of a cycle with a host read in flight.
    step(0, 0, 0, 0, 1, 0, 32'h8, 0);
    @(posedge clk_100mhz);
    #1 host_req_in = 1; host_we_in = 0; host_addr_in = 32'hC;
    #1 rst_in = 1;
    #1;
    chk("mid_rst_host_gnt", {31'b0, host_gnt_out}, 32'h0);
    chk("mid_rst_host_rvalid", {31'b0, host_rvalid_out}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy_out}, 32'h0);
    chk("mid_rst_ram_addr", {20'b0, ram_addr_out}, 32'h0);
    chk("mid_rst_host_rdata", host_rdata_out, 32'h0);
    host_req_in = 0;
    @(posedge clk_100mhz);
    @(posedge clk_100mhz);
    #3 rst_in = 0;
    pend.delete();
    m_last = 1'b1;
    m_hold = '0;
    idle(3);
    // First contention after reset goes to the core.
    step(1, 0, 32'h10, 0, 1, 0, 32'h14, 0);
    idle(3);

    // Random traffic over the preloaded region.
    for (int i = 0; i < 400; i++) begin
      ra = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      rb = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rb[1:0] = 2'($urandom_range(1, 3));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rb, $urandom);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data BRAM (xilinx_single_port_ram_read_first, HIGH_PERFORMANCE) between the processor core's load/store path and a host/debug port, which preloads and inspects data memory. One access is granted per cycle. Read returns are tracked through a tag pipeline matched to the RAM read latency, so each read response goes only to the port that issued it. The block sits between the execute/writeback stage and data_mem.

## Interface
Parameters:
- ADDR_W, 12: word-address width driven to the RAM (depth 2^ADDR_W).
- DATA_W, 32: data width.
- RD_LATENCY, 2: RAM cycles from address to douta. Legal values are 1 and 2.

Ports:
- clk_100mhz  in  1  sole clock; all state on posedge.
- rst_in  in  1  asynchronous, active-high reset.
- core_req_in  in  1  core requests an access this cycle.
- core_we_in  in  1  1 = store, 0 = load.
- core_addr_in  in  32  byte address.
- core_wdata_in  in  DATA_W  store data.
- core_gnt_out  out  1  core access accepted this cycle.
- core_rvalid_out  out  1  core read response valid.
- core_rdata_out  out  DATA_W  core read data.
- core_err_out  out  1  core misaligned-access response (pulses with rvalid).
- host_req_in, host_we_in, host_addr_in, host_wdata_in, host_gnt_out, host_rvalid_out, host_rdata_out, host_err_out: same as the core_* set, for the host port.
- ram_addr_out  out  ADDR_W  to RAM addra.
- ram_din_out  out  DATA_W  to RAM dina.
- ram_we_out  out  1  to RAM wea.
- ram_dout_in  in  DATA_W  from RAM douta.
- busy_out  out  1  at least one read is in flight.

## Operation
- Grant logic is combinational from the req inputs and a registered last_gnt pointer.
  - At most one gnt is high per cycle.
  - A gnt is high only when the matching req is high.
- Contention (both ports request): the winner is chosen by the arbitration policy (see Configuration).
- A requester holding req high sees one accepted access per granted cycle. Sustained single-port streams run at 1 access per cycle.
- Granted access:
  - ram_addr_out = addr[ADDR_W+1:2].
  - ram_din_out = wdata.
  - ram_we_out = we.
- No grant: ram_we_out = 0, ram_addr_out holds its last value, ram_din_out = 0.
- Misaligned access (addr[1:0] != 0):
  - The access is still granted, but ram_we_out is forced to 0, so no write occurs.
  - A response is always issued, for loads and stores alike: rvalid=1, err=1, rdata=0, at the normal read-return cycle.
- Tag pipeline: RD_LATENCY stages, each holding {valid, port, err}. A stage entry is valid only for granted loads and for misaligned accesses. Aligned stores generate no response.
- Response: the stage-RD_LATENCY entry drives rvalid/err of its tagged port. rdata = ram_dout_in when not err. The other port's rvalid is 0.
- rdata_out is 0 whenever its port's rvalid is 0.
- busy_out = OR of the valid bits across the tag pipeline.
- The RAM's own rsta must be tied to rst_in by the parent, so RAM output and tag pipeline clear together.

## Timing
- Reset values:
  - All *_gnt_out, *_rvalid_out and *_err_out are 0.
  - All rdata, ram_addr_out and ram_din_out are 0.
  - ram_we_out = 0; busy_out = 0.
  - last_gnt = HOST, so CORE wins the first contention.
- Grant latency: 0 cycles (gnt in the same cycle as req).
- Read latency: rvalid occurs exactly RD_LATENCY cycles after the gnt cycle (cycle N grant gives cycle N+2 rvalid at the default).
- Write: the RAM is written at the posedge ending the gnt cycle.
- Read-after-write to the same address in back-to-back grants returns the new data, because the write completes before the next read's address edge.
- Reset asserted mid-operation:
  - All in-flight tags are dropped immediately; no rvalid is issued for them.
  - Outputs take their reset values asynchronously.
- Reset deasserted: arbitration resumes on the first clock edge after deassertion.
- last_gnt updates on every granted cycle, including uncontended ones.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On contention, the port that is not last_gnt wins, so alternating grants occur under continuous dual request.
- DMEM_ARB_RR_EN undefined: fixed priority. CORE always wins on contention. The host can starve, and this is accepted for single-cycle core operation. last_gnt is still maintained but ignored.

## Structure
- Shared package dmem_arb_pkg holds:
  - typedef enum logic {PORT_CORE=1'b0, PORT_HOST=1'b1} port_t.
  - Packed struct rd_tag_t {logic valid; port_t port; logic err;}.
  - localparam DMEM_RD_LATENCY_DEFAULT = 2.
- One sub-module, dmem_rd_tag_pipe: an RD_LATENCY-deep shift register of rd_tag_t with asynchronous clear. It outputs the tail entry and the busy OR.

## Test plan
- Reset: assert rst_in mid-clock with a host read in flight -> all outputs 0 immediately; no host_rvalid afterwards.
- Core alone: store 0xDEADBEEF to 0x40, then load 0x40 the next cycle -> core_gnt both cycles; core_rvalid 2 cycles after the load gnt with rdata 0xDEADBEEF; ram_addr 0x010.
- Contention, RR on: both ports load continuously for 6 cycles -> gnt alternates CORE, HOST, CORE, ...; each rvalid is routed to the correct port 2 cycles later.
- Contention, RR off: same stimulus -> core_gnt every cycle, host_gnt never; host granted the cycle core_req drops.
- Misaligned: host store to 0x41 -> host_gnt=1, ram_we_out=0, RAM contents unchanged; host_rvalid=1 and host_err=1 with rdata 0 two cycles later.
- Pipelining: core loads 0x0, 0x4, 0x8 back-to-back -> three consecutive core_rvalid cycles in order; busy_out high throughout, low 1 cycle after the last rvalid.
